rx_frame_assembler: RTL

RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

---
 rtl/rx_frame_pkg.sv | 25 ++
 rtl/rx_frame_assembler_if.sv | 30 +++
 rtl/rx_frame_fifo.sv | 49 ++++
 rtl/rx_frame_assembler.sv | 86 ++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared constants, FSM encoding and frame record for the RX frame assembler
package rx_frame_pkg;

   localparam int FRAME_BYTES = 3;

   localparam int         DEF_FIFO_DEPTH  = 4;
   localparam int         DEF_TIMEOUT_CYC = 2000;
   localparam logic [7:0] DEF_ADDR_A      = 8'h0A;
   localparam logic [7:0] DEF_ADDR_B      = 8'h0B;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GOT_ADDR = 2'd1;
   localparam logic [1:0] ST_GOT_D0   = 2'd2;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] d0;
      logic [7:0] d1;
   } frame_t;

   function automatic logic addr_match(input logic [7:0] a, input logic [7:0] x, input logic [7:0] y);
      return (a == x) || (a == y);
   endfunction

endpackage

// File: rtl/rx_frame_assembler_if.sv
// rx_frame_assembler_if: byte input, FIFO read/control and status bundle of the frame assembler
interface rx_frame_assembler_if import rx_frame_pkg::*; #(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

   logic [7:0]                   S_DATA;
   logic                         INT;
   logic                         rd_en;
   logic                         clr_ovf;
   logic [7:0]                   frame_addr;
   logic [7:0]                   frame_d0;
   logic [7:0]                   frame_d1;
   logic                         empty;
   logic                         full;
   logic [$clog2(FIFO_DEPTH):0]  count;
   logic                         overflow;
   logic                         bad_addr;
   logic                         timeout;

   modport master (
      output S_DATA, INT, rd_en, clr_ovf,
      input  frame_addr, frame_d0, frame_d1, empty, full, count, overflow, bad_addr, timeout
   );

   modport slave (
      input  S_DATA, INT, rd_en, clr_ovf,
      output frame_addr, frame_d0, frame_d1, empty, full, count, overflow, bad_addr, timeout
   );

endinterface

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: show-ahead frame FIFO with occupancy count and sticky overflow
module rx_frame_fifo import rx_frame_pkg::*; #(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   PCLK,
   input  logic                   PRESETN,
   input  logic                   push,
   input  frame_t                 din,
   input  logic                   pop,
   input  logic                   clr_ovf,
   output frame_t                 dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   frame_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage, power-of-two wrapping pointers, count and sticky overflow (a new drop beats clr_ovf)
   always_ff @(posedge PCLK or negedge PRESETN)
      if (!PRESETN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count    <= count + CW'(do_push) - CW'(do_pop);
         overflow <= (push & full & ~do_pop) | (overflow & ~clr_ovf);
      end

endmodule

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: collects addr/d0/d1 byte triples from the I2C slave stage into a frame FIFO
module rx_frame_assembler import rx_frame_pkg::*; #(
   parameter int         FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter logic [7:0] ADDR_A      = DEF_ADDR_A,
   parameter logic [7:0] ADDR_B      = DEF_ADDR_B
) (
   input logic                 PCLK,
   input logic                 PRESETN,
   rx_frame_assembler_if.slave bus
);

   localparam int GW = $clog2(TIMEOUT_CYC) + 1;

   logic          int_q, accept, expire;
   logic [1:0]    state;
   logic [GW-1:0] gap;
   logic [7:0]    addr_r, d0_r;
   frame_t        frame_q, head;
   logic          push_q, bad_q, tmo_q;

   assign accept = bus.INT & ~int_q;
   assign expire = (state != ST_IDLE) && !accept && (gap == GW'(TIMEOUT_CYC - 1));

   assign bus.frame_addr = head.addr;
   assign bus.frame_d0   = head.d0;
   assign bus.frame_d1   = head.d1;
   assign bus.bad_addr   = bad_q;
   assign bus.timeout    = tmo_q;

   // INT edge detector; resets high so a level already high at reset release is not a byte
   always_ff @(posedge PCLK or negedge PRESETN)
      if (!PRESETN) int_q <= 1'b1;
      else          int_q <= bus.INT;

   // Byte collector FSM with inter-byte gap supervision; completed frames leave one cycle later
   always_ff @(posedge PCLK or negedge PRESETN)
      if (!PRESETN) begin
         state   <= ST_IDLE;
         gap     <= '0;
         addr_r  <= '0;
         d0_r    <= '0;
         frame_q <= '0;
         push_q  <= 1'b0;
         bad_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         push_q <= 1'b0;
         bad_q  <= 1'b0;
         tmo_q  <= expire;
         gap    <= (accept || expire || state == ST_IDLE) ? '0 : gap + 1'b1;
         if (accept)
            case (state)
               ST_IDLE: begin
                  addr_r <= bus.S_DATA;
                  state  <= ST_GOT_ADDR;
               end
               ST_GOT_ADDR: begin
                  d0_r  <= bus.S_DATA;
                  state <= ST_GOT_D0;
               end
               default: begin
                  frame_q <= {addr_r, d0_r, bus.S_DATA};
                  push_q  <= addr_match(addr_r, ADDR_A, ADDR_B);
                  bad_q   <= !addr_match(addr_r, ADDR_A, ADDR_B);
                  state   <= ST_IDLE;
               end
            endcase
         else if (expire) state <= ST_IDLE;
      end

   rx_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .PCLK     (PCLK),
      .PRESETN  (PRESETN),
      .push     (push_q),
      .din      (frame_q),
      .pop      (bus.rd_en),
      .clr_ovf  (bus.clr_ovf),
      .dout     (head),
      .empty    (bus.empty),
      .full     (bus.full),
      .count    (bus.count),
      .overflow (bus.overflow)
   );

endmodule
